// File: rtl/pong_game_controller.sv
// Pong match sequencer.
// Gates the ball tracker with game_on and pulses its active-low reset when a
// rally starts. Turns the tracker's sticky point flags into single score
// increments. Runs the serve delay, detects the winning score and holds the
// game-over condition until the next start press.
module pong_game_controller #(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 50000000,
  parameter int SCORE_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_btn,
  input  logic               player1_point,
  input  logic               player2_point,
  output logic               game_on,
  output logic               ball_reset_n,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [1:0]         winner,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SERVE = 2'b01,
    ST_PLAY  = 2'b10,
    ST_OVER  = 2'b11
  } state_e;

  localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD   = CNT_W'(SERVE_DELAY - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ZERO   = '0;
  localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_ZERO = '0;
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
  localparam logic [1:0]         WIN_NONE   = 2'b00;
  localparam logic [1:0]         WIN_P1     = 2'b01;
  localparam logic [1:0]         WIN_P2     = 2'b10;

  // Out-of-range parameters would let a score wrap before anyone wins.
  generate
    if ((WIN_SCORE < 1) || (WIN_SCORE > ((2 ** SCORE_W) - 1))) begin : g_bad_win_score
      $error("pong_game_controller: WIN_SCORE outside 1..2**SCORE_W-1");
    end
    if (SERVE_DELAY < 1) begin : g_bad_serve_delay
      $error("pong_game_controller: SERVE_DELAY must be at least 1");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] score1_q, score1_d;
  logic [SCORE_W-1:0] score2_q, score2_d;
  logic [1:0]         winner_q, winner_d;
  logic               game_on_q, game_on_d;
  logic               ball_reset_n_q, ball_reset_n_d;
  logic               start_prev_q, p1_prev_q, p2_prev_q;

  logic               edge_start_s, edge_p1_s, edge_p2_s;
  logic               enter_serve_s;
  logic [SCORE_W-1:0] score1_inc_s, score2_inc_s;

  // Rising-edge detection; histories reset high so a level held through reset is not an edge.
  assign edge_start_s = start_btn & ~start_prev_q;
  assign edge_p1_s    = player1_point & ~p1_prev_q;
  assign edge_p2_s    = player2_point & ~p2_prev_q;
  assign score1_inc_s = score1_q + SCORE_ONE;
  assign score2_inc_s = score2_q + SCORE_ONE;

  // Next-state, counter, score and winner logic; every route into SERVE reloads the counter.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    score1_d      = score1_q;
    score2_d      = score2_q;
    winner_d      = winner_q;
    enter_serve_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (edge_start_s) begin
          state_d       = ST_SERVE;
          cnt_d         = CNT_LOAD;
          enter_serve_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVE: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_PLAY;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_PLAY: begin
        if (edge_p1_s && edge_p2_s) begin
          // Simultaneous points: replay the rally without scoring.
          state_d       = ST_SERVE;
          cnt_d         = CNT_LOAD;
          enter_serve_s = 1'b1;
        end else if (edge_p1_s) begin
          score1_d = score1_inc_s;
          if (score1_inc_s == WIN_VAL) begin
            state_d  = ST_OVER;
            winner_d = WIN_P1;
          end else begin
            state_d       = ST_SERVE;
            cnt_d         = CNT_LOAD;
            enter_serve_s = 1'b1;
          end
        end else if (edge_p2_s) begin
          score2_d = score2_inc_s;
          if (score2_inc_s == WIN_VAL) begin
            state_d  = ST_OVER;
            winner_d = WIN_P2;
          end else begin
            state_d       = ST_SERVE;
            cnt_d         = CNT_LOAD;
            enter_serve_s = 1'b1;
          end
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_OVER: begin
        if (edge_start_s) begin
          // New match goes straight to a serve.
          score1_d      = SCORE_ZERO;
          score2_d      = SCORE_ZERO;
          winner_d      = WIN_NONE;
          state_d       = ST_SERVE;
          cnt_d         = CNT_LOAD;
          enter_serve_s = 1'b1;
        end else begin
          state_d = ST_OVER;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cnt_d    = CNT_ZERO;
        score1_d = SCORE_ZERO;
        score2_d = SCORE_ZERO;
        winner_d = WIN_NONE;
      end
    endcase
    game_on_d      = (state_d == ST_PLAY);
    ball_reset_n_d = ~enter_serve_s;
  end

  // State, datapath and edge-history registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= CNT_ZERO;
      score1_q       <= SCORE_ZERO;
      score2_q       <= SCORE_ZERO;
      winner_q       <= WIN_NONE;
      game_on_q      <= 1'b0;
      ball_reset_n_q <= 1'b0;
      start_prev_q   <= 1'b1;
      p1_prev_q      <= 1'b1;
      p2_prev_q      <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      score1_q       <= score1_d;
      score2_q       <= score2_d;
      winner_q       <= winner_d;
      game_on_q      <= game_on_d;
      ball_reset_n_q <= ball_reset_n_d;
      start_prev_q   <= start_btn;
      p1_prev_q      <= player1_point;
      p2_prev_q      <= player2_point;
    end
  end

  assign game_on      = game_on_q;
  assign ball_reset_n = ball_reset_n_q;
  assign score1       = score1_q;
  assign score2       = score2_q;
  assign winner       = winner_q;
  assign state        = state_q;

endmodule

// File: tb/tb_pong_game_controller.sv
// Bench for pong_game_controller with SERVE_DELAY=4, WIN_SCORE=3.
// A match-level model predicts every output each cycle; directed steps add
// literal expectations at key points of the match.
module tb_pong_game_controller;

  localparam int WIN   = 3;
  localparam int DELAY = 4;

  logic       clk;
  logic       reset;
  logic       start_btn;
  logic       player1_point;
  logic       player2_point;
  logic       game_on;
  logic       ball_reset_n;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [1:0] winner;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  pong_game_controller #(
    .WIN_SCORE  (WIN),
    .SERVE_DELAY(DELAY),
    .SCORE_W    (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start_btn    (start_btn),
    .player1_point(player1_point),
    .player2_point(player2_point),
    .game_on      (game_on),
    .ball_reset_n (ball_reset_n),
    .score1       (score1),
    .score2       (score2),
    .winner       (winner),
    .state        (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- match model ----------------
  // phase: 0 idle, 1 serving, 2 playing, 3 match over
  int m_phase, m_left, m_s1, m_s2, m_win, m_brn;
  bit m_valid = 1'b0;
  bit h_start, h_p1, h_p2;

  function automatic void m_serve();
    m_phase = 1;
    m_left  = DELAY;
    m_brn   = 0;
  endfunction

  always @(posedge clk) begin
    bit rs, r1, r2;
    rs = start_btn && !h_start;
    r1 = player1_point && !h_p1;
    r2 = player2_point && !h_p2;
    if (!reset) begin
      m_phase = 0; m_left = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_brn = 0;
      h_start = 1'b1; h_p1 = 1'b1; h_p2 = 1'b1;
      m_valid = 1'b1;
    end else begin
      m_brn = 1;
      if (m_phase == 0) begin
        if (rs) m_serve();
      end else if (m_phase == 1) begin
        m_left = m_left - 1;
        if (m_left == 0) m_phase = 2;
      end else if (m_phase == 2) begin
        if (r1 && r2) m_serve();
        else if (r1) begin
          m_s1 = m_s1 + 1;
          if (m_s1 == WIN) begin m_phase = 3; m_win = 1; end
          else m_serve();
        end else if (r2) begin
          m_s2 = m_s2 + 1;
          if (m_s2 == WIN) begin m_phase = 3; m_win = 2; end
          else m_serve();
        end
      end else begin
        if (rs) begin m_s1 = 0; m_s2 = 0; m_win = 0; m_serve(); end
      end
      h_start = start_btn; h_p1 = player1_point; h_p2 = player2_point;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_state",   32'(state),        32'(m_phase));
      chk("m_game_on", 32'(game_on),      32'(m_phase == 2));
      chk("m_brn",     32'(ball_reset_n), 32'(m_brn));
      chk("m_score1",  32'(score1),       32'(m_s1));
      chk("m_score2",  32'(score2),       32'(m_s2));
      chk("m_winner",  32'(winner),       32'(m_win));
    end
  end

  // ---------------- directed stimulus ----------------
  // which: 0 start, 1 player1, 2 player2, 3 both players; high for one sampling edge.
  task automatic pulse(input int which);
    @(posedge clk); #2;
    if (which == 0) start_btn = 1'b1;
    if (which == 1 || which == 3) player1_point = 1'b1;
    if (which == 2 || which == 3) player2_point = 1'b1;
    @(posedge clk); #2;
    start_btn = 1'b0; player1_point = 1'b0; player2_point = 1'b0;
  endtask

  task automatic wait_play();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (state !== 2'b10 && n < 20);
    chk("wait_play", 32'(state), 32'd2);
  endtask

  task automatic step_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int serve_cnt, low_cnt;
    reset = 1'b0; start_btn = 1'b0; player1_point = 1'b0; player2_point = 1'b0;

    // 1: reset then release
    @(negedge clk);
    chk("rst_brn", 32'(ball_reset_n), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    @(posedge clk); #2 reset = 1'b1;
    step_edge();
    chk("rel_brn", 32'(ball_reset_n), 32'd1);
    chk("rel_state", 32'(state), 32'd0);
    chk("rel_scores", 32'({score1, score2}), 32'd0);
    chk("rel_winner", 32'(winner), 32'd0);
    chk("rel_game_on", 32'(game_on), 32'd0);

    // 2: start held 20 cycles
    @(posedge clk); #2 start_btn = 1'b1;
    serve_cnt = 0; low_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (state === 2'b01) serve_cnt++;
      if (ball_reset_n === 1'b0) low_cnt++;
    end
    chk("serve_len", 32'(serve_cnt), 32'd4);
    chk("serve_brn_low", 32'(low_cnt), 32'd1);
    chk("serve_to_play", 32'(state), 32'd2);
    chk("play_game_on", 32'(game_on), 32'd1);
    @(posedge clk); #2 start_btn = 1'b0;

    // 3: player1 flag held 10 cycles
    @(posedge clk); #2 player1_point = 1'b1;
    step_edge();
    chk("p1_score1", 32'(score1), 32'd1);
    chk("p1_state", 32'(state), 32'd1);
    chk("p1_brn", 32'(ball_reset_n), 32'd0);
    chk("p1_score2", 32'(score2), 32'd0);
    repeat (9) @(negedge clk);
    chk("p1_held_score1", 32'(score1), 32'd1);
    chk("p1_held_state", 32'(state), 32'd2);
    @(posedge clk); #2 player1_point = 1'b0;

    // 4: simultaneous points
    @(posedge clk); #2 player1_point = 1'b1; player2_point = 1'b1;
    step_edge();
    chk("both_state", 32'(state), 32'd1);
    chk("both_scores", 32'({score1, score2}), 32'h10);
    @(posedge clk); #2 player1_point = 1'b0; player2_point = 1'b0;
    wait_play();

    // 5: player2 wins, then new match
    pulse(2); wait_play();
    pulse(2); wait_play();
    chk("s2_two", 32'(score2), 32'd2);
    pulse(2);
    @(negedge clk);
    chk("win_scores", 32'({score1, score2}), 32'h13);
    chk("win_winner", 32'(winner), 32'd2);
    chk("win_state", 32'(state), 32'd3);
    chk("win_game_on", 32'(game_on), 32'd0);
    pulse(1); pulse(2); pulse(3);
    @(negedge clk);
    chk("over_hold_scores", 32'({score1, score2}), 32'h13);
    chk("over_hold_state", 32'(state), 32'd3);
    @(posedge clk); #2 start_btn = 1'b1;
    step_edge();
    chk("new_scores", 32'({score1, score2}), 32'd0);
    chk("new_winner", 32'(winner), 32'd0);
    chk("new_state", 32'(state), 32'd1);

    // 6a: reset in second serve cycle (start still held)
    @(posedge clk); #2 reset = 1'b0;
    step_edge();
    chk("rs_serve_state", 32'(state), 32'd0);
    chk("rs_serve_game_on", 32'(game_on), 32'd0);
    chk("rs_serve_scores", 32'({score1, score2}), 32'd0);
    @(posedge clk); #2 reset = 1'b1;
    step_edge();
    step_edge();
    chk("held_start_no_edge", 32'(state), 32'd0);
    @(posedge clk); #2 start_btn = 1'b0;

    // 6b: reset mid-play with score1=2
    pulse(0); wait_play();
    pulse(1); wait_play();
    pulse(1); wait_play();
    chk("pre_rst_score1", 32'(score1), 32'd2);
    @(posedge clk); #2 reset = 1'b0;
    step_edge();
    chk("rs_play_state", 32'(state), 32'd0);
    chk("rs_play_score1", 32'(score1), 32'd0);
    chk("rs_play_game_on", 32'(game_on), 32'd0);
    chk("rs_play_winner", 32'(winner), 32'd0);
    @(posedge clk); #2 reset = 1'b1;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
